// File: rtl/noc_pkg.sv
// ============================================================================
// Module : noc_pkg
// Brief  : Flit header layout, port indices and route decode shared by the leaf switch.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package noc_pkg;

    localparam int DATA_W    = 16;
    localparam int HEADER_W  = 6;

    localparam int GRP_MSB   = 15;
    localparam int GRP_LSB   = 12;
    localparam int LEAF_MSB  = 11;
    localparam int LEAF_LSB  = 10;

    localparam int NUM_PORTS = 5;
    localparam logic [2:0] P_NI0  = 3'd0;
    localparam logic [2:0] P_NI1  = 3'd1;
    localparam logic [2:0] P_NI2  = 3'd2;
    localparam logic [2:0] P_NI3  = 3'd3;
    localparam logic [2:0] P_UP   = 3'd4;
    localparam logic [2:0] P_DROP = 3'd7;

    // hdr is the flit's top HEADER_W bits: {group, leaf}
    function automatic logic [2:0] route_port(input logic [HEADER_W-1:0] hdr,
                                              input logic [3:0]          group_id,
                                              input logic                from_up);
        logic [3:0] grp;
        logic [1:0] leaf;
        grp  = hdr[GRP_MSB-LEAF_LSB : GRP_LSB-LEAF_LSB];
        leaf = hdr[LEAF_MSB-LEAF_LSB : 0];
        if (grp == 4'd0)
            return P_DROP;
        if (grp == group_id)
            return {1'b0, leaf};
        if (from_up)
            return P_DROP;
        return P_UP;
    endfunction

    function automatic logic [2:0] port_wrap(input logic [2:0] base, input logic [2:0] offs);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, offs};
        return (sum >= 4'(NUM_PORTS)) ? 3'(sum - 4'(NUM_PORTS)) : sum[2:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_flit_fifo.sv
// ============================================================================
// Module : noc_flit_fifo
// Brief  : Per-input flit buffer with occupancy count and head-of-line view.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module noc_flit_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [DATA_W-1:0]         head,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !reset)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/leaf_router.sv
// ============================================================================
// Module : leaf_router
// Brief  : Group leaf switch: 4 NI ports + 1 uplink, buffered inputs, round-robin outputs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module leaf_router #(
    parameter logic [3:0] GROUP_ID  = 4'd8,
    parameter int         DATA_W    = 16,
    parameter int         HEADER_W  = 6,
    parameter int         BUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DATA_W-1:0]   ni_data_in,
    input  logic [3:0]            ni_valid_in,
    output logic [3:0]            ni_ready_out,
    output logic [4*DATA_W-1:0]   ni_data_out,
    output logic [3:0]            ni_valid_out,
    input  logic [DATA_W-1:0]     up_data_in,
    input  logic                  up_valid_in,
    output logic                  up_ready_out,
    output logic [DATA_W-1:0]     up_data_out,
    output logic                  up_valid_out,
    input  logic                  up_ready_in,
    output logic [7:0]            drop_cnt
);

    import noc_pkg::*;

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [DATA_W-1:0]    in_data [NUM_PORTS];
    logic [DATA_W-1:0]    head    [NUM_PORTS];
    logic [CNT_W-1:0]     cnt     [NUM_PORTS];
    logic [2:0]           dest    [NUM_PORTS];
    logic [2:0]           gnt_idx [NUM_PORTS];
    logic [2:0]           rr_ptr  [NUM_PORTS];
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] drop;
    logic [NUM_PORTS-1:0] gnt_vld;
    logic [2:0]           ndrop;
    logic [8:0]           drop_sum;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_fifo
            if (gi == int'(P_UP)) begin : g_up
                assign push[gi]    = up_valid_in && up_ready_out;
                assign in_data[gi] = up_data_in;
            end else begin : g_ni
                assign push[gi]    = ni_valid_in[gi];
                assign in_data[gi] = ni_data_in[gi*DATA_W +: DATA_W];
            end

            noc_flit_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (BUF_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .push      (push[gi]),
                .push_data (in_data[gi]),
                .pop       (pop[gi]),
                .head      (head[gi]),
                .count     (cnt[gi])
            );
        end
    endgenerate

    // Credit-style NI: the flit in flight this cycle is counted, pops are not.
    always_comb begin
        ni_ready_out = '0;
        for (int k = 0; k < 4; k++)
            ni_ready_out[k] = !reset &&
                (({1'b0, cnt[k]} + {{CNT_W{1'b0}}, ni_valid_in[k]}) < (CNT_W+1)'(BUF_DEPTH));
    end

    assign up_ready_out = !reset && (cnt[P_UP] < CNT_W'(BUF_DEPTH));

    always_comb begin
        logic [2:0] cand;
        logic       grantable;
        drop    = '0;
        gnt_vld = '0;
        ndrop   = '0;
        cand    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            dest[i] = route_port(head[i][DATA_W-1 -: HEADER_W], GROUP_ID, i == int'(P_UP));
            drop[i] = (cnt[i] != '0) && (dest[i] == P_DROP);
            ndrop   = ndrop + {2'b00, drop[i]};
        end
        pop = drop;
        for (int o = 0; o < NUM_PORTS; o++) begin
            gnt_idx[o] = '0;
            grantable  = (o != int'(P_UP)) || !up_valid_out || up_ready_in;
            for (int off = 0; off < NUM_PORTS; off++) begin
                cand = port_wrap(rr_ptr[o], off[2:0]);
                if (grantable && !gnt_vld[o] && (cnt[cand] != '0) && (dest[cand] == 3'(o))) begin
                    gnt_vld[o] = 1'b1;
                    gnt_idx[o] = cand;
                end
            end
            if (gnt_vld[o])
                pop[gnt_idx[o]] = 1'b1;
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + {6'b0, ndrop};

    always_ff @(posedge clk) begin
        if (reset) begin
            ni_valid_out <= '0;
            ni_data_out  <= '0;
            up_valid_out <= 1'b0;
            up_data_out  <= '0;
            drop_cnt     <= '0;
            for (int o = 0; o < NUM_PORTS; o++)
                rr_ptr[o] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                ni_valid_out[k] <= gnt_vld[k];
                if (gnt_vld[k])
                    ni_data_out[k*DATA_W +: DATA_W] <= head[gnt_idx[k]];
            end
            // Uplink output holds its flit until the group router takes it.
            if (gnt_vld[P_UP]) begin
                up_valid_out <= 1'b1;
                up_data_out  <= head[gnt_idx[P_UP]];
            end else if (up_ready_in) begin
                up_valid_out <= 1'b0;
            end
            for (int o = 0; o < NUM_PORTS; o++)
                if (gnt_vld[o])
                    rr_ptr[o] <= port_wrap(gnt_idx[o], 3'd1);
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_leaf_router.sv
// ============================================================================
// Module : tb_leaf_router
// Brief  : Directed scenarios plus credit-respecting random traffic against a scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_leaf_router;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] ni_data_in = '0;
    logic [3:0]  ni_valid_in = '0;
    logic [3:0]  ni_ready_out;
    logic [63:0] ni_data_out;
    logic [3:0]  ni_valid_out;
    logic [15:0] up_data_in = '0;
    logic        up_valid_in = 1'b0;
    logic        up_ready_out;
    logic [15:0] up_data_out;
    logic        up_valid_out;
    logic        up_ready_in = 1'b0;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    leaf_router #(
        .GROUP_ID  (4'd8),
        .DATA_W    (16),
        .HEADER_W  (6),
        .BUF_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ni_data_in   (ni_data_in),
        .ni_valid_in  (ni_valid_in),
        .ni_ready_out (ni_ready_out),
        .ni_data_out  (ni_data_out),
        .ni_valid_out (ni_valid_out),
        .up_data_in   (up_data_in),
        .up_valid_in  (up_valid_in),
        .up_ready_out (up_ready_out),
        .up_data_out  (up_data_out),
        .up_valid_out (up_valid_out),
        .up_ready_in  (up_ready_in),
        .drop_cnt     (drop_cnt)
    );

    int          checks = 0;
    int          errors = 0;
    int          model_drops = 0;
    int          seq = 0;
    logic [15:0] sb [25][$];
    logic [15:0] f;
    logic [3:0]  rdy_prev;
    logic        rdy2;
    int          sent;
    int          got;
    bit          just_sent;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Destination from the routing rules alone; -1 means the flit is dropped.
    function automatic int exp_dst(input logic [15:0] fl, input int src);
        if (fl[15:12] == 4'd0) return -1;
        if (fl[15:12] == 4'd8) return int'(fl[11:10]);
        if (src == 4) return -1;
        return 4;
    endfunction

    task automatic model_accept(input logic [15:0] fl, input int src);
        int d;
        d = exp_dst(fl, src);
        if (d < 0) model_drops++;
        else sb[src*5 + d].push_back(fl);
    endtask

    task automatic sb_check(input int dst, input logic [15:0] d);
        int src;
        src = int'(d[9:7]);
        if (src < 5 && sb[src*5 + dst].size() > 0)
            chk($sformatf("sb_order_p%0d", dst), {48'h0, d}, {48'h0, sb[src*5 + dst].pop_front()});
        else
            chk($sformatf("sb_unexpected_p%0d", dst), {48'h0, d}, 64'h1_0000);
    endtask

    function automatic logic [15:0] rand_flit(input int src, input int sq);
        logic [3:0] g;
        int r;
        r = $urandom_range(0, 7);
        if (r == 0)      g = 4'd0;
        else if (r <= 4) g = 4'd8;
        else if (r == 7) g = 4'd3;
        else             g = 4'($urandom_range(1, 15));
        return {g, 2'($urandom_range(0, 3)), 3'(src), 7'(sq)};
    endfunction

    initial begin
        // 1. Reset with random inputs
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ni_valid_in = 4'($urandom);
            ni_data_in  = {$urandom, $urandom};
            up_valid_in = 1'($urandom);
            up_data_in  = 16'($urandom);
            up_ready_in = 1'($urandom);
            #1;
            chk("rst_ctrl", {46'h0, ni_valid_out, up_valid_out, ni_ready_out, up_ready_out, drop_cnt}, 64'h0);
            chk("rst_data", ni_data_out | {48'h0, up_data_out}, 64'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        ni_valid_in = '0;
        up_valid_in = 1'b0;
        up_ready_in = 1'b1;
        #1;
        chk("rel_ni_ready", {60'h0, ni_ready_out}, 64'hF);
        chk("rel_up_ready", {63'h0, up_ready_out}, 64'h1);

        // 2. Local switch NI0 -> port 2
        @(negedge clk);
        ni_valid_in = 4'b0001;
        ni_data_in[15:0] = 16'h8923;
        @(negedge clk);
        ni_valid_in = '0;
        chk("local_early", {60'h0, ni_valid_out}, 64'h0);
        @(negedge clk);
        chk("local_valid", {60'h0, ni_valid_out}, 64'h4);
        chk("local_data", {48'h0, ni_data_out[47:32]}, 64'h8923);
        @(negedge clk);
        chk("local_pulse", {60'h0, ni_valid_out}, 64'h0);

        // 3. Uplink hold under backpressure
        up_ready_in = 1'b0;
        ni_valid_in = 4'b0010;
        ni_data_in[31:16] = 16'h3400;
        @(negedge clk);
        ni_valid_in = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("up_hold", {47'h0, up_valid_out, up_data_out}, {47'h0, 1'b1, 16'h3400});
        end
        up_ready_in = 1'b1;
        @(negedge clk);
        chk("up_released", {63'h0, up_valid_out}, 64'h0);

        // 4. Contention on port 0, two rounds
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            ni_valid_in = 4'hF;
            ni_data_in  = {16'h8103, 16'h8102, 16'h8101, 16'h8100};
            up_valid_in = 1'b1;
            up_data_in  = 16'h8104;
            @(negedge clk);
            ni_valid_in = '0;
            up_valid_in = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk($sformatf("cont_r%0d_k%0d", r, k), {44'h0, ni_valid_out, ni_data_out[15:0]},
                    {44'h0, 4'b0001, 16'h8100 + 16'(k)});
            end
            @(negedge clk);
            chk("cont_idle", {60'h0, ni_valid_out}, 64'h0);
        end

        // 5. Credit stream NI2 -> uplink with uplink stalled
        up_ready_in = 1'b0;
        #1;
        rdy2 = ni_ready_out[2];
        sent = 0;
        got  = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            if (c == 12) up_ready_in = 1'b1;
            just_sent = 1'b0;
            if (rdy2 && sent < 6) begin
                ni_valid_in[2] = 1'b1;
                ni_data_in[47:32] = 16'h3500 + 16'(sent);
                sent++;
                just_sent = 1'b1;
            end else begin
                ni_valid_in[2] = 1'b0;
            end
            #1;
            rdy2 = ni_ready_out[2];
            if (just_sent && sent == 4 && !up_ready_in) chk("credit_room", {63'h0, rdy2}, 64'h1);
            if (just_sent && sent == 5 && !up_ready_in) chk("credit_full", {63'h0, rdy2}, 64'h0);
            if (c == 10)
                chk("credit_stall", {45'h0, rdy2, up_valid_out, 1'b0, up_data_out}, {45'h0, 1'b0, 1'b1, 1'b0, 16'h3500});
            if (up_valid_out && up_ready_in) begin
                chk("credit_order", {48'h0, up_data_out}, {48'h0, 16'h3500 + 16'(got)});
                got++;
            end
        end
        ni_valid_in = '0;
        chk("credit_count", 64'(got), 64'd6);

        // 6. Drops and saturation
        @(negedge clk);
        ni_valid_in = 4'b1000;
        ni_data_in[63:48] = 16'h0042;
        up_valid_in = 1'b1;
        up_data_in  = 16'h5000;
        @(negedge clk);
        ni_valid_in = '0;
        up_valid_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("drop_quiet", {59'h0, ni_valid_out, up_valid_out}, 64'h0);
        end
        chk("drop_two", {56'h0, drop_cnt}, 64'd2);
        up_valid_in = 1'b1;
        for (int c = 0; c < 260; c++) @(negedge clk);
        up_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("drop_sat", {56'h0, drop_cnt}, 64'd255);

        // Mid-operation reset discards buffered flits
        up_ready_in = 1'b0;
        ni_valid_in = 4'b0001;
        ni_data_in[15:0] = 16'h3777;
        @(negedge clk);
        ni_data_in[15:0] = 16'h3778;
        @(negedge clk);
        ni_valid_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_clear", {55'h0, up_valid_out, drop_cnt}, 64'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_empty", {59'h0, ni_valid_out, up_valid_out}, 64'h0);

        // Random traffic against the scoreboard
        #1;
        rdy_prev = ni_ready_out;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                if (ni_valid_out[k]) sb_check(k, ni_data_out[k*16 +: 16]);
            if (c < 400) begin
                for (int k = 0; k < 4; k++) begin
                    if (rdy_prev[k] && ($urandom_range(0, 1) == 1)) begin
                        f = rand_flit(k, seq);
                        seq++;
                        ni_valid_in[k] = 1'b1;
                        ni_data_in[k*16 +: 16] = f;
                        model_accept(f, k);
                    end else begin
                        ni_valid_in[k] = 1'b0;
                    end
                end
                up_valid_in = ($urandom_range(0, 2) == 0);
                up_data_in  = rand_flit(4, seq);
                seq++;
                up_ready_in = ($urandom_range(0, 3) != 0);
            end else begin
                ni_valid_in = '0;
                up_valid_in = 1'b0;
                up_ready_in = 1'b1;
            end
            #1;
            rdy_prev = ni_ready_out;
            if (up_valid_in && up_ready_out) model_accept(up_data_in, 4);
            if (up_valid_out && up_ready_in) sb_check(4, up_data_out);
        end
        for (int i = 0; i < 25; i++)
            chk($sformatf("sb_drained_%0d", i), 64'(sb[i].size()), 64'd0);
        chk("rand_drop_cnt", {56'h0, drop_cnt}, (model_drops > 255) ? 64'd255 : 64'(model_drops));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
